// File: rtl/spi_master_16bit_if.sv
// Bundle between the ADXL345 sequencer, the SPI master and the sensor pins.
// The master modport is the view of the SPI master itself.
interface spi_master_16bit_if;
    localparam int unsigned WORD_W = 16;

    logic              start;
    logic [WORD_W-1:0] data_in_16bit;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] data_out_16bit;
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;

    modport master (
        input  start,
        input  data_in_16bit,
        input  miso,
        output busy,
        output done,
        output data_out_16bit,
        output sclk,
        output cs_n,
        output mosi
    );

    modport slave (
        output start,
        output data_in_16bit,
        output miso,
        input  busy,
        input  done,
        input  data_out_16bit,
        input  sclk,
        input  cs_n,
        input  mosi
    );
endinterface

// File: rtl/spi_master_16bit.sv
// SPI mode-3 master: one 16-bit MSB-first full-duplex frame per start request,
// with programmable SCLK half-period and cs_n setup/hold/gap timing.
module spi_master_16bit #(
    parameter int unsigned CLK_DIV  = 20,
    parameter int unsigned CS_SETUP = 10,
    parameter int unsigned CS_HOLD  = 10,
    parameter int unsigned CS_GAP   = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    spi_master_16bit_if.master bus
);

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        HOLD     = 3'd4,
        GAP      = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [WORD_W-1:0] tx_q, tx_d;
    logic [WORD_W-1:0] rx_q, rx_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              mosi_q, mosi_d;
    logic              miso_meta, miso_sync;

    logic [CNT_W-1:0]  div_inc;
    logic              setup_last, div_last, hold_last, gap_last, bit_last;

    assign div_inc    = div_q + CNT_W'(1);
    assign setup_last = (div_q == CNT_W'(CS_SETUP - 1));
    assign div_last   = (div_q == CNT_W'(CLK_DIV - 1));
    assign hold_last  = (div_q == CNT_W'(CS_HOLD - 1));
    assign gap_last   = (div_q == CNT_W'(CS_GAP - 1));
    assign bit_last   = (bit_q == BIT_W'(WORD_W - 1));

    // miso is asynchronous to clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= bus.miso;
            miso_sync <= miso_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
        end
    end

    // Next-state and registered-output logic; the last bit's rising edge goes
    // straight to HOLD so there is no trailing SCLK-high half-period.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_d    = bus.data_in_16bit;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (setup_last) begin
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    mosi_d  = tx_q[WORD_W-1];
                    tx_d    = {tx_q[WORD_W-2:0], 1'b0};
                    state_d = SHIFT_LO;
                end else begin
                    div_d = div_inc;
                end
            end
            SHIFT_LO: begin
                if (div_last) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[WORD_W-2:0], miso_sync};
                    state_d = bit_last ? HOLD : SHIFT_HI;
                end else begin
                    div_d = div_inc;
                end
            end
            SHIFT_HI: begin
                if (bit_last) begin
                    div_d   = '0;
                    state_d = HOLD;
                end else if (div_last) begin
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    mosi_d  = tx_q[WORD_W-1];
                    tx_d    = {tx_q[WORD_W-2:0], 1'b0};
                    bit_d   = bit_q + BIT_W'(1);
                    state_d = SHIFT_LO;
                end else begin
                    div_d = div_inc;
                end
            end
            HOLD: begin
                if (hold_last) begin
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                end else begin
                    div_d = div_inc;
                end
            end
            GAP: begin
                if (gap_last) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                    state_d = IDLE;
                end else begin
                    div_d = div_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.data_out_16bit = dout_q;
    assign bus.sclk           = sclk_q;
    assign bus.cs_n           = cs_n_q;
    assign bus.mosi           = mosi_q;

endmodule

// File: tb/tb_spi_master_16bit.sv
// Self-checking bench for spi_master_16bit: a pin-level monitor plus a mode-3
// slave model record each frame; directed and random frames are checked.
module tb_spi_master_16bit;

    localparam int CLK_DIV     = 20;
    localparam int CS_SETUP    = 10;
    localparam int CS_HOLD     = 10;
    localparam int CS_GAP      = 20;
    localparam int BUSY_LEN    = CS_SETUP + 31 * CLK_DIV + CS_HOLD + CS_GAP;
    localparam int CS_HIGH_B2B = CS_GAP + 1;
    localparam int WAIT_MAX    = 3 * BUSY_LEN;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    spi_master_16bit_if bus ();

    spi_master_16bit #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic use_rand;
    logic rand_miso;
    logic slave_miso;
    assign bus.miso = use_rand ? rand_miso : slave_miso;

    typedef struct {
        int          busy_len;
        int          setup;
        int          hold;
        int          falls;
        int          rises;
        int          viol;
        int          busy_low;
        int          cs_high;
        logic        done;
        logic [15:0] mosi_word;
        logic [15:0] dout;
    } frame_t;

    frame_t      frames[$];
    logic [15:0] slave_q[$];
    logic [15:0] b2b_sw[6];

    int checks, errors;
    int cyc, n_fall, n_rise, n_launch, done_cnt, glitch;
    int cs_fall_cyc, cs_rise_cyc, last_rise_cyc, busy_rise_cyc, busy_fall_cyc;
    int cur_setup, cur_hold, cur_viol, cur_busy_low, cur_cs_high;
    logic [15:0] cur_mosi, cur_sw, p_dout;
    logic p_sclk, p_cs, p_mosi, p_busy;

    initial begin
        cyc = 0; n_fall = 0; n_rise = 0; n_launch = 0; done_cnt = 0; glitch = 0;
        cs_fall_cyc = 0; cs_rise_cyc = 0; last_rise_cyc = 0;
        busy_rise_cyc = 0; busy_fall_cyc = 0;
        cur_setup = 0; cur_hold = 0; cur_viol = 0; cur_busy_low = 0; cur_cs_high = 0;
        cur_mosi = '0; cur_sw = '0; slave_miso = 1'b0;
    end

    // Pin monitor and mode-3 slave: slave shifts its word out MSB first on SCLK falls.
    always begin
        @(negedge clk);
        cyc++;
        if (reset_n === 1'b1) begin
            if (p_cs && !bus.cs_n) begin
                cs_fall_cyc = cyc;
                cur_cs_high = cyc - cs_rise_cyc;
                n_fall = 0; n_rise = 0; cur_viol = 0; cur_mosi = '0;
                cur_sw = '0;
                if (slave_q.size() > 0) cur_sw = slave_q.pop_front();
            end
            if (!p_cs && bus.cs_n) begin
                cur_hold    = cyc - last_rise_cyc;
                cs_rise_cyc = cyc;
            end
            if (p_sclk && !bus.sclk) begin
                n_fall++;
                if (n_fall == 1) cur_setup = cyc - cs_fall_cyc;
                cur_mosi   = {cur_mosi[14:0], bus.mosi};
                slave_miso = cur_sw[15];
                cur_sw     = {cur_sw[14:0], 1'b0};
                if (bus.cs_n) cur_viol++;
            end else if (!p_cs && !bus.cs_n && bus.mosi !== p_mosi) begin
                cur_viol++;
            end
            if (!p_sclk && bus.sclk) begin
                n_rise++;
                last_rise_cyc = cyc;
            end
            if (bus.cs_n && !bus.sclk) cur_viol++;
            if (!p_busy && bus.busy) begin
                n_launch++;
                busy_rise_cyc = cyc;
                cur_busy_low  = cyc - busy_fall_cyc;
            end
            if (p_busy && !bus.busy) begin
                busy_fall_cyc = cyc;
                frames.push_back('{busy_len: cyc - busy_rise_cyc, setup: cur_setup,
                                   hold: cur_hold, falls: n_fall, rises: n_rise,
                                   viol: cur_viol, busy_low: cur_busy_low,
                                   cs_high: cur_cs_high, done: bus.done,
                                   mosi_word: cur_mosi, dout: bus.data_out_16bit});
            end
            if (bus.done) done_cnt++;
            if (bus.data_out_16bit !== p_dout && !bus.done) glitch++;
        end else begin
            n_fall = 0; n_rise = 0; cur_viol = 0;
        end
        p_sclk = bus.sclk;
        p_cs   = bus.cs_n;
        p_mosi = bus.mosi;
        p_busy = bus.busy;
        p_dout = bus.data_out_16bit;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k;
        k = 0;
        while (frames.size() < n && k < WAIT_MAX) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(frames.size() >= n), 32'd1);
    endtask

    task automatic wait_launch(input int n, input string tag);
        int k;
        k = 0;
        while (n_launch < n && k < WAIT_MAX) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(n_launch >= n), 32'd1);
    endtask

    task automatic wait_fall(input int n, input string tag);
        int k;
        k = 0;
        while (n_fall < n && k < WAIT_MAX) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(n_fall >= n), 32'd1);
    endtask

    task automatic launch(input logic [15:0] tx, input logic [15:0] sw, input int pulse);
        slave_q.push_back(sw);
        bus.data_in_16bit = tx;
        bus.start = 1'b1;
        repeat (pulse) @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_frame(input int idx, input logic [15:0] tx, input logic [15:0] rx,
                               input string tag);
        frame_t f;
        if (idx >= frames.size()) begin
            chk({tag, "_present"}, 32'(frames.size()), 32'(idx + 1));
            return;
        end
        f = frames[idx];
        chk({tag, "_busy_len"}, f.busy_len, BUSY_LEN);
        chk({tag, "_cs_setup"}, f.setup, CS_SETUP);
        chk({tag, "_cs_hold"}, f.hold, CS_HOLD);
        chk({tag, "_falls"}, f.falls, 16);
        chk({tag, "_rises"}, f.rises, 16);
        chk({tag, "_pin_viol"}, f.viol, 0);
        chk({tag, "_done_at_fall"}, 32'(f.done), 32'd1);
        chk({tag, "_mosi"}, 32'(f.mosi_word), 32'(tx));
        chk({tag, "_dout"}, 32'(f.dout), 32'(rx));
    endtask

    initial begin
        int base, lbase, dbase;
        logic [15:0] tx, sw, tx2;
        checks = 0; errors = 0;

        // 1: reset with random start/miso
        reset_n = 1'b0; use_rand = 1'b1; rand_miso = 1'b0;
        bus.start = 1'b0; bus.data_in_16bit = '0;
        for (int i = 0; i < 8; i++) begin
            bus.start = 1'($urandom);
            rand_miso = 1'($urandom);
            bus.data_in_16bit = 16'($urandom);
            @(negedge clk);
            chk("reset_outputs", {bus.busy, bus.done, bus.sclk, bus.cs_n, bus.mosi,
                                  bus.data_out_16bit}, {5'b00110, 16'h0000});
        end
        bus.start = 1'b0; use_rand = 1'b0;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 2: write frame, 10-cycle start pulse
        base = frames.size(); lbase = n_launch; dbase = done_cnt;
        launch(16'h2D08, 16'h0000, 10);
        wait_frames(base + 1, "t2_complete");
        repeat (30) @(negedge clk);
        check_frame(base, 16'h2D08, 16'h0000, "t2");
        chk("t2_single_launch", n_launch - lbase, 1);
        chk("t2_single_done", done_cnt - dbase, 1);

        // 3: read frame
        base = frames.size();
        launch(16'hB200, 16'h005A, 1);
        wait_frames(base + 1, "t3_complete");
        @(negedge clk);
        check_frame(base, 16'hB200, 16'h005A, "t3");
        chk("t3_dout_after", 32'(bus.data_out_16bit), 32'h005A);

        // 4: extra starts and data_in changes mid-frame are ignored
        base = frames.size(); lbase = n_launch;
        tx = 16'($urandom); sw = 16'($urandom);
        launch(tx, sw, 1);
        foreach (b2b_sw[i]) b2b_sw[i] = '0;
        wait_fall(4, "t4_bit3");
        tx2 = ~tx; bus.data_in_16bit = tx2; bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_fall(13, "t4_bit12");
        bus.data_in_16bit = 16'($urandom); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_frames(base + 1, "t4_complete");
        repeat (60) @(negedge clk);
        check_frame(base, tx, sw, "t4");
        chk("t4_single_launch", n_launch - lbase, 1);

        // 5: start held high across six frames
        base = frames.size(); lbase = n_launch;
        for (int i = 0; i < 6; i++) begin
            b2b_sw[i] = 16'($urandom);
            slave_q.push_back(b2b_sw[i]);
        end
        bus.data_in_16bit = 16'hB200; bus.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_launch(lbase + i + 1, "t5_launch");
            if (i == 5) bus.start = 1'b0;
            else bus.data_in_16bit = 16'(32'hB200 + (i + 1) * 256);
        end
        wait_frames(base + 6, "t5_complete");
        repeat (30) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check_frame(base + i, 16'(32'hB200 + i * 256), b2b_sw[i], "t5");
            if (i > 0 && base + i < frames.size()) begin
                chk("t5_busy_low", frames[base + i].busy_low, 1);
                chk("t5_cs_high", frames[base + i].cs_high, CS_HIGH_B2B);
            end
        end
        chk("t5_launches", n_launch - lbase, 6);

        // 6: asynchronous reset at bit 7, then a normal frame
        base = frames.size();
        launch(16'($urandom), 16'($urandom), 1);
        wait_fall(8, "t6_bit7");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_async_reset", {bus.busy, bus.done, bus.sclk, bus.cs_n, bus.mosi,
                               bus.data_out_16bit}, {5'b00110, 16'h0000});
        repeat (3) @(negedge clk);
        chk("t6_reset_held", {bus.busy, bus.done, bus.sclk, bus.cs_n, bus.mosi,
                              bus.data_out_16bit}, {5'b00110, 16'h0000});
        reset_n = 1'b1;
        slave_q.delete();
        repeat (4) @(negedge clk);
        chk("t6_no_frame_logged", frames.size(), base);
        sw = 16'($urandom);
        launch(16'hB300, sw, 1);
        wait_frames(base + 1, "t6_complete");
        repeat (5) @(negedge clk);
        check_frame(base, 16'hB300, sw, "t6");

        chk("dout_stable_between_done", glitch, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_16bit.md
Name: spi_master_16bit

Overview:
- SPI mode-3 master (CPOL=1, CPHA=1) that executes one 16-bit full-duplex transfer per request. It sits directly downstream of the ADXL345 sequencing controller.
- The controller supplies start and data_in_16bit. This block returns busy and data_out_16bit and drives the ADXL345 4-wire pins.
- Frame is MSB first: the address/command byte in [15:8], the data byte in [7:0].
- Designed for a 100 MHz clk; the default SCLK is 2.5 MHz.

Parameters:
- CLK_DIV, 20: SCLK half-period in clk cycles. Must be >= 4.
- CS_SETUP, 10: cycles from cs_n falling to the first SCLK falling edge. Must be >= 1.
- CS_HOLD, 10: cycles from the last SCLK rising edge to cs_n rising. Must be >= 1.
- CS_GAP, 20: minimum cs_n-high cycles before busy deasserts (ADXL345 tCS,DIS 150 ns). Must be >= 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  transfer request; level-sampled only in IDLE.
- data_in_16bit  in  16  transmit word; captured on the launch edge.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse, coincident with busy falling.
- data_out_16bit  out  16  last received word; held until the next completion.
- sclk  out  1  SPI clock; idles high.
- cs_n  out  1  chip select, active low.
- mosi  out  1  master data out.
- miso  in  1  slave data in; asynchronous, passed through a 2-flop synchroniser.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - Outputs: busy=0, done=0, data_out_16bit=0, sclk=1, cs_n=1, mosi=0.
  - Internal: state=IDLE; shift register, receive register, counters and synchroniser all cleared.
- States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP.
- IDLE:
  - If start=1, the launch edge performs: tx_shreg<=data_in_16bit, busy<=1, cs_n<=0, bit_cnt<=0, div_cnt<=0, then go to SETUP.
  - If start=0, remain in IDLE.
- SETUP: after CS_SETUP cycles: sclk<=0, mosi<=tx_shreg[15], go to SHIFT_LO.
- SHIFT_LO: after CLK_DIV cycles: sclk<=1 and rx_shreg<={rx_shreg[14:0], miso_sync}, go to SHIFT_HI.
- SHIFT_HI:
  - If bit_cnt=15, go to HOLD immediately on the same edge the state is entered. sclk stays high; there is no trailing high half-period.
  - Otherwise, after CLK_DIV cycles: sclk<=0, mosi<=next bit (MSB to LSB), bit_cnt+1, go to SHIFT_LO.
- HOLD: after CS_HOLD cycles: cs_n<=1, mosi<=0, go to GAP.
- GAP: after CS_GAP cycles: busy<=0, done<=1 (one cycle), data_out_16bit<=rx_shreg, go to IDLE.
- Frame shape:
  - Exactly 16 SCLK falling edges and 16 rising edges per frame.
  - mosi changes only on SCLK falling edges while cs_n=0.
  - miso is sampled on the clk edge that drives sclk 0->1. Synchroniser latency is 2 cycles, which is less than CLK_DIV.
- Busy duration: busy is high for exactly CS_SETUP + 31*CLK_DIV + CS_HOLD + CS_GAP cycles, which is 660 with the defaults.
- data_out_16bit is valid in the same cycle busy reads 0. The upstream controller samples it one cycle after the busy falling edge, so it must remain stable until the next done.
- start while busy=1 is ignored; a request is never queued.
- start held high continuously:
  - The next transfer launches on the first IDLE cycle, so busy is low for exactly 1 cycle between frames.
  - cs_n is high for CS_GAP+1 cycles between frames.
- data_in_16bit changes after the launch edge have no effect on the frame in progress.
- A start pulse of 1 cycle is sufficient. The upstream controller's 10-cycle pulse produces exactly one transfer.

Test Plan:
1. Reset: hold reset_n=0 with random start/miso -> busy=0, done=0, sclk=1, cs_n=1, mosi=0, data_out_16bit=0x0000 throughout.
2. Write frame: start=1 for 10 cycles with data_in_16bit=0x2D08, miso=0 ->
   - mosi at successive SCLK falling edges reads 0010110100001000.
   - 16 rising edges; busy high exactly 660 cycles.
   - done pulses once; data_out_16bit=0x0000.
3. Read frame: data_in_16bit=0xB200; mode-3 slave model drives 0x00 during the address byte and 0x5A during the data byte ->
   - data_out_16bit=0x005A, valid when busy falls and stable until the next done.
   - First SCLK fall occurs 10 cycles after cs_n falls; cs_n rises 10 cycles after the last SCLK rise.
4. Ignore during busy: extra start pulses and data_in_16bit changes at bits 3 and 12 -> a single frame only, with the originally captured word shifted out.
5. Back-to-back: start held high across 6 frames 0xB200..0xB700 -> busy low exactly 1 cycle between frames, cs_n high 21 cycles between frames, each data_out_16bit matches the slave model.
6. Reset mid-shift: assert reset_n=0 at bit_cnt=7 ->
   - Outputs return to reset values asynchronously, before the next clk edge.
   - After release, a 0xB300 frame completes normally with correct data and 660-cycle busy.
